abro_session_controller: RTL and testbench

ABRO_SESSION_CONTROLLER -- requirements
Module: abro_session_controller

---
 rtl/abro_session_controller.sv | 146 ++++++++++++++
 tb/tb_abro_session_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/abro_session_controller.sv
// Sequences ABRO datapath sessions: arm (hold datapath reset), accept one A and one B event, report done or timeout.
// Latency: accept edge N -> abro_A/abro_B pulse cycle N+1 -> abro_O seen cycle N+2 -> done cycle N+3.
// Backpressure: evt_*_ready is high only in WAIT while that requester has not yet been accepted this session.
module abro_session_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned REARM_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       evt_a_valid,
    output logic       evt_a_ready,
    input  logic       evt_b_valid,
    output logic       evt_b_ready,
    output logic       abro_A,
    output logic       abro_B,
    output logic       abro_reset_n,
    input  logic       abro_O,
    output logic       done,
    output logic       timeout,
    output logic       busy,
    output logic [7:0] session_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_DONE,
        S_TOUT
    } state_t;

    localparam logic [3:0] REARM_LAST   = 4'(REARM_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] rearm_cnt_q, rearm_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       a_seen_q, a_seen_d;
    logic       b_seen_q, b_seen_d;
    logic [7:0] session_cnt_q, session_cnt_d;
    logic       abro_a_q, abro_a_d;
    logic       abro_b_q, abro_b_d;
    logic       abro_rst_n_q, abro_rst_n_d;

    // Next-state, handshake and counter update logic.
    always_comb begin
        state_d       = state_q;
        rearm_cnt_d   = '0;
        wait_cnt_d    = '0;
        a_seen_d      = a_seen_q;
        b_seen_d      = b_seen_q;
        session_cnt_d = session_cnt_q;
        evt_a_ready   = 1'b0;
        evt_b_ready   = 1'b0;
        abro_a_d      = 1'b0;
        abro_b_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_ARM;
                end
            end

            S_ARM: begin
                // Session bookkeeping starts clean; counters already default to zero.
                a_seen_d = 1'b0;
                b_seen_d = 1'b0;
                if (!en) begin
                    state_d = S_IDLE;
                end else if (rearm_cnt_q == REARM_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    rearm_cnt_d = rearm_cnt_q + 4'd1;
                end
            end

            S_WAIT: begin
                evt_a_ready = !a_seen_q;
                evt_b_ready = !b_seen_q;
                abro_a_d    = evt_a_valid && !a_seen_q;
                abro_b_d    = evt_b_valid && !b_seen_q;
                a_seen_d    = a_seen_q | abro_a_d;
                b_seen_d    = b_seen_q | abro_b_d;
                wait_cnt_d  = wait_cnt_q + 8'd1;
                // Disable beats everything; completion beats the timeout on the last cycle.
                if (!en) begin
                    state_d = S_IDLE;
                end else if (abro_O) begin
                    state_d = S_DONE;
                    if (session_cnt_q != 8'hFF) begin
                        session_cnt_d = session_cnt_q + 8'd1;
                    end
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d = S_TOUT;
                end
            end

            S_DONE, S_TOUT: begin
                state_d = en ? S_ARM : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Datapath is held in reset whenever no session is open.
        abro_rst_n_d = !(state_d == S_IDLE || state_d == S_ARM);
    end

    // State, counters and registered datapath drives; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rearm_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            a_seen_q      <= 1'b0;
            b_seen_q      <= 1'b0;
            session_cnt_q <= '0;
            abro_a_q      <= 1'b0;
            abro_b_q      <= 1'b0;
            abro_rst_n_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rearm_cnt_q   <= rearm_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            a_seen_q      <= a_seen_d;
            b_seen_q      <= b_seen_d;
            session_cnt_q <= session_cnt_d;
            abro_a_q      <= abro_a_d;
            abro_b_q      <= abro_b_d;
            abro_rst_n_q  <= abro_rst_n_d;
        end
    end

    assign abro_A       = abro_a_q;
    assign abro_B       = abro_b_q;
    assign abro_reset_n = abro_rst_n_q;
    assign done         = (state_q == S_DONE);
    assign timeout      = (state_q == S_TOUT);
    assign busy         = (state_q != S_IDLE);
    assign session_cnt  = session_cnt_q;

endmodule

// File: tb/tb_abro_session_controller.sv
module tb_abro_session_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       evt_a_valid;
    logic       evt_b_valid;
    logic       evt_a_ready;
    logic       evt_b_ready;
    logic       abro_A;
    logic       abro_B;
    logic       abro_reset_n;
    logic       abro_O;
    logic       done;
    logic       timeout;
    logic       busy;
    logic [7:0] session_cnt;

    logic       dp_a;
    logic       dp_b;

    int n_vec;
    int n_err;

    typedef struct {
        logic       is_done;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] exp_cnt;

    abro_session_controller #(
        .TIMEOUT_CYCLES(16),
        .REARM_CYCLES  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .evt_a_valid (evt_a_valid),
        .evt_a_ready (evt_a_ready),
        .evt_b_valid (evt_b_valid),
        .evt_b_ready (evt_b_ready),
        .abro_A      (abro_A),
        .abro_B      (abro_B),
        .abro_reset_n(abro_reset_n),
        .abro_O      (abro_O),
        .done        (done),
        .timeout     (timeout),
        .busy        (busy),
        .session_cnt (session_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural ABRO datapath: O rises the cycle after both A and B have been seen, cleared by reset_n.
    always @(posedge clk) begin
        if (abro_reset_n !== 1'b1) begin
            dp_a   <= 1'b0;
            dp_b   <= 1'b0;
            abro_O <= 1'b0;
        end else begin
            dp_a   <= dp_a | abro_A;
            dp_b   <= dp_b | abro_B;
            abro_O <= abro_O | ((dp_a | abro_A) & (dp_b | abro_B));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic is_done);
        exp_t e;
        if (is_done && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e.is_done = is_done;
        e.cnt     = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!(evt_a_ready || evt_b_ready) && n < 32) begin
            step();
            n++;
        end
        check(tag, 32'(evt_a_ready | evt_b_ready), 32'd1);
    endtask

    task automatic wait_result(input string tag, output int lat);
        exp_t e;
        int n = 0;
        while (!(done || timeout) && n < 64) begin
            step();
            n++;
        end
        lat = n;
        e = sb_q.pop_front();
        check({tag, "_done"}, 32'(done), 32'(e.is_done));
        check({tag, "_tout"}, 32'(timeout), 32'(!e.is_done));
        check({tag, "_cnt"}, 32'(session_cnt), 32'(e.cnt));
    endtask

    task automatic after_result(input string tag, input logic exp_busy);
        step();
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_tout_1cyc"}, 32'(timeout), 32'd0);
        check({tag, "_rearm_rstn"}, 32'(abro_reset_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        int lat;
        int n;
        int na;
        int nb;
        int pulses;

        n_vec       = 0;
        n_err       = 0;
        exp_cnt     = 8'd0;
        reset       = 1'b1;
        en          = 1'b0;
        evt_a_valid = 1'b0;
        evt_b_valid = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_rstn", 32'(abro_reset_n), 32'd0);
        check("rst_ab", 32'({abro_A, abro_B}), 32'd0);
        check("rst_rdy", 32'({evt_a_ready, evt_b_ready}), 32'd0);
        check("rst_flags", 32'({done, timeout, busy}), 32'd0);
        check("rst_cnt", 32'(session_cnt), 32'd0);

        // Session 1: re-arm length, A then B three cycles later, done latency
        reset = 1'b0;
        en    = 1'b1;
        step();
        n = 0;
        while (busy && !abro_reset_n && n < 20) begin
            n++;
            step();
        end
        check("arm_len", 32'(n), 32'd2);
        check("s1_rdy_a", 32'(evt_a_ready), 32'd1);
        check("s1_rdy_b", 32'(evt_b_ready), 32'd1);
        evt_a_valid = 1'b1;
        step();
        evt_a_valid = 1'b0;
        check("s1_a_pulse", 32'(abro_A), 32'd1);
        check("s1_a_rdy_low", 32'(evt_a_ready), 32'd0);
        step();
        check("s1_a_pulse_end", 32'(abro_A), 32'd0);
        step();
        evt_b_valid = 1'b1;
        push_exp(1'b1);
        step();
        evt_b_valid = 1'b0;
        check("s1_b_pulse", 32'(abro_B), 32'd1);
        wait_result("s1", lat);
        check("s1_lat", 32'(lat), 32'd2);
        after_result("s1", 1'b1);

        // Session 2: simultaneous A and B
        wait_ready("s2_wait");
        evt_a_valid = 1'b1;
        evt_b_valid = 1'b1;
        push_exp(1'b1);
        step();
        evt_a_valid = 1'b0;
        evt_b_valid = 1'b0;
        check("s2_ab_pulse", 32'({abro_A, abro_B}), 32'd3);
        wait_result("s2", lat);
        check("s2_lat", 32'(lat), 32'd2);
        after_result("s2", 1'b1);

        // Session 3: only A offered and held high -> timeout after 16 WAIT cycles
        wait_ready("s3_wait");
        evt_a_valid = 1'b1;
        push_exp(1'b0);
        n  = 0;
        na = 0;
        nb = 0;
        while (!timeout && n < 64) begin
            if (evt_b_ready) nb++;
            if (abro_A) na++;
            step();
            n++;
        end
        check("s3_brdy_cycles", 32'(nb), 32'd16);
        check("s3_a_pulses", 32'(na), 32'd1);
        wait_result("s3", lat);
        after_result("s3", 1'b1);
        evt_a_valid = 1'b0;

        // Session 4: completion lands exactly on the last WAIT cycle -> done wins
        wait_ready("s4_wait");
        evt_a_valid = 1'b1;
        step();
        evt_a_valid = 1'b0;
        repeat (12) step();
        evt_b_valid = 1'b1;
        push_exp(1'b1);
        step();
        evt_b_valid = 1'b0;
        wait_result("s4_edge", lat);
        check("s4_lat", 32'(lat), 32'd2);
        after_result("s4", 1'b1);

        // Session 5: en dropped mid-WAIT -> IDLE with no pulse
        wait_ready("s5_wait");
        evt_a_valid = 1'b1;
        step();
        evt_a_valid = 1'b0;
        repeat (2) step();
        en = 1'b0;
        step();
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_rstn", 32'(abro_reset_n), 32'd0);
        check("s5_rdy", 32'({evt_a_ready, evt_b_ready}), 32'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (done || timeout) pulses++;
            step();
        end
        check("s5_no_pulse", 32'(pulses), 32'd0);
        check("s5_cnt", 32'(session_cnt), 32'(exp_cnt));

        // Session 6: reset mid-WAIT overrides an acceptance in progress
        en = 1'b1;
        wait_ready("s6_wait");
        evt_a_valid = 1'b1;
        reset       = 1'b1;
        step();
        evt_a_valid = 1'b0;
        exp_cnt     = 8'd0;
        check("s6_cnt", 32'(session_cnt), 32'd0);
        check("s6_ab", 32'({abro_A, abro_B}), 32'd0);
        check("s6_rstn", 32'(abro_reset_n), 32'd0);
        check("s6_flags", 32'({done, timeout, busy}), 32'd0);
        check("s6_rdy", 32'({evt_a_ready, evt_b_ready}), 32'd0);
        reset = 1'b0;

        // 256 back-to-back sessions -> counter saturates at 255
        for (int s = 0; s < 256; s++) begin
            wait_ready("sat_wait");
            evt_a_valid = 1'b1;
            evt_b_valid = 1'b1;
            push_exp(1'b1);
            step();
            evt_a_valid = 1'b0;
            evt_b_valid = 1'b0;
            wait_result("sat", lat);
        end
        step();
        check("sat_hold", 32'(session_cnt), 32'd255);

        en = 1'b0;
        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
